// File: rtl/register_bank_pkg.sv
// Mode encodings and the write-result bundle shared by the register bank and its op unit.
// Result value is sized to the widest supported word; users take the low WIDTH bits.
package register_bank_pkg;

  localparam logic [2:0] MODE_NOP   = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_CLEAR = 3'd2;
  localparam logic [2:0] MODE_INC   = 3'd3;
  localparam logic [2:0] MODE_DEC   = 3'd4;
  localparam logic [2:0] MODE_SHL   = 3'd5;
  localparam logic [2:0] MODE_SHR   = 3'd6;
  localparam logic [2:0] MODE_RSVD  = 3'd7;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] value;
    logic                 carry;
    logic                 zero;
  } op_result_t;

endpackage

// File: rtl/reg_op_unit.sv
// Combinational write-path ALU: computes the new register value, carry and zero for one mode.
// NOP and the reserved code pass the old value through; illegal flags the reserved code.
module reg_op_unit
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] old_value,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       mode,
  output op_result_t       res,
  output logic             illegal
);

  logic [WIDTH-1:0] nv;
  logic [WIDTH:0]   sum;
  logic             cy;

  always_comb begin
    nv  = old_value;
    cy  = 1'b0;
    sum = '0;
    case (mode)
      MODE_LOAD:  nv = wr_data;
      MODE_CLEAR: nv = '0;
      MODE_INC: begin
        sum = {1'b0, old_value} + (WIDTH+1)'(1);
        nv  = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
      end
      MODE_DEC: begin
        nv = old_value - WIDTH'(1);
        cy = (old_value == '0);
      end
      MODE_SHL: begin
        nv = {old_value[WIDTH-2:0], 1'b0};
        cy = old_value[WIDTH-1];
      end
      MODE_SHR: begin
        nv = {1'b0, old_value[WIDTH-1:1]};
        cy = old_value[0];
      end
      default: ;
    endcase
    res                  = '0;
    res.value[WIDTH-1:0] = nv;
    res.carry            = cy;
    res.zero             = (nv == '0);
  end

  assign illegal = (mode == MODE_RSVD);

endmodule

// File: rtl/register_bank.sv
// General-purpose register set: one load/clear/inc/dec/shift write and two write-first reads per cycle.
// Reads and status are registered (1-cycle latency); there is no back-pressure.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_mode,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              wr_done,
  output logic              flag_carry,
  output logic              flag_zero,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] old_value, new_value, rd_next_a, rd_next_b;
  op_result_t       res;
  logic             illegal, addr_ok, accept, store, err_next;

  assign addr_ok   = ({1'b0, wr_addr} < DEPTH_L);
  assign old_value = addr_ok ? regs[wr_addr] : '0;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .old_value (old_value),
    .wr_data   (wr_data),
    .mode      (wr_mode),
    .res       (res),
    .illegal   (illegal)
  );

  assign new_value = res.value[WIDTH-1:0];

  generate
    if (WIDTH < MAX_WIDTH) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^res.value[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

  // A NOP never raises err, even when aimed at a nonexistent register.
  assign accept   = wr_en && addr_ok && !illegal && (wr_mode != MODE_NOP);
  assign store    = accept && !(ZERO_R0 && (wr_addr == '0));
  assign err_next = wr_en && (wr_mode != MODE_NOP) && (illegal || !addr_ok);

  // Register 0 under ZERO_R0 is never stored, so plain array reads already return 0 for it.
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    if ({1'b0, rd_addr_a} < DEPTH_L)
      rd_next_a = (store && (rd_addr_a == wr_addr)) ? new_value : regs[rd_addr_a];
    if ({1'b0, rd_addr_b} < DEPTH_L)
      rd_next_b = (store && (rd_addr_b == wr_addr)) ? new_value : regs[rd_addr_b];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      wr_done    <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (store) regs[wr_addr] <= new_value;
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
      wr_done   <= accept;
      err       <= err_next;
      if (accept) begin
        flag_carry <= res.carry;
        flag_zero  <= res.zero;
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Drives two banks (8 regs plain, 6 regs with ZERO_R0) from shared stimulus and checks both
// against an array-based model; the 6-deep bank is where out-of-range write/read addresses exist.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [2:0]  wr_mode = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;

  logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        done0, carry0, zero0, err0;
  logic        done1, carry1, zero1, err1;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a0), .rd_data_b(rd_b0), .wr_done(done0),
    .flag_carry(carry0), .flag_zero(zero0), .err(err0));

  register_bank #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a1), .rd_data_b(rd_b1), .wr_done(done1),
    .flag_carry(carry1), .flag_zero(zero1), .err(err1));

  logic [35:0] obs [2];
  assign obs[0] = {rd_a0, rd_b0, done0, carry0, zero0, err0};
  assign obs[1] = {rd_a1, rd_b1, done1, carry1, zero1, err1};

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_regs [2][8];
  bit          m_c [2], m_z [2], e_done [2], e_err [2];
  logic [15:0] e_rda [2], e_rdb [2];

  function automatic logic [35:0] expv(int d);
    return {e_rda[d], e_rdb[d], e_done[d], m_c[d], m_z[d], e_err[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++) m_regs[d][r] = 0;
      m_c[d] = 0; m_z[d] = 0; e_done[d] = 0; e_err[d] = 0;
      e_rda[d] = '0; e_rdb[d] = '0;
    end
  endtask

  // Apply the write to the register array first, then read it back: that is write-first.
  task automatic model_step(int d);
    int depth, old, res, c;
    depth = (d == 0) ? 8 : 6;
    e_done[d] = 0;
    e_err[d]  = 0;
    if (wr_en && wr_mode != 0) begin
      if (wr_mode == 7 || int'(wr_addr) >= depth) e_err[d] = 1;
      else begin
        old = m_regs[d][wr_addr];
        c = 0;
        case (wr_mode)
          1: res = int'(wr_data);
          2: res = 0;
          3: begin res = old + 1; if (res == 65536) begin res = 0; c = 1; end end
          4: begin res = old - 1; if (res < 0) begin res = 65535; c = 1; end end
          5: begin res = old * 2; c = (res >= 65536); res = res % 65536; end
          default: begin c = old % 2; res = old / 2; end
        endcase
        m_c[d] = c[0];
        m_z[d] = (res == 0);
        e_done[d] = 1;
        if (!(d == 1 && wr_addr == 0)) m_regs[d][wr_addr] = res;
      end
    end
    e_rda[d] = (int'(rd_addr_a) < depth) ? 16'(m_regs[d][rd_addr_a]) : 16'h0;
    e_rdb[d] = (int'(rd_addr_b) < depth) ? 16'(m_regs[d][rd_addr_b]) : 16'h0;
  endtask

  task automatic drive(bit en, int mode, int addr, int data, int ra, int rb);
    wr_en = en; wr_mode = 3'(mode); wr_addr = 3'(addr); wr_data = 16'(data);
    rd_addr_a = 3'(ra); rd_addr_b = 3'(rb);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== 36'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d got %h exp 0", d, obs[d]);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_load_read();
    drive(1, 1, 3, 16'hABCD, 3, 0);
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== expv(d)) begin
        n_fail++;
        $display("FAIL load_read dut%0d got %h exp %h", d, obs[d], expv(d));
      end
    end
    n_checks++;
    if ({rd_a0, done0, carry0, zero0} !== {16'hABCD, 3'b100}) begin
      n_fail++;
      $display("FAIL load_read_const got %h/%b%b%b exp abcd/100", rd_a0, done0, carry0, zero0);
    end
  endtask

  task automatic test_inc_dec_wrap();
    int mode [3] = '{1, 3, 4};
    logic [17:0] want [3] = '{{16'hFFFF, 2'b00}, {16'h0000, 2'b11}, {16'hFFFF, 2'b10}};
    for (int i = 0; i < 3; i++) begin
      drive(1, mode[i], 5, 16'hFFFF, 0, 5);
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== expv(d)) begin
          n_fail++;
          $display("FAIL inc_dec[%0d] dut%0d got %h exp %h", i, d, obs[d], expv(d));
        end
      end
      n_checks++;
      if ({rd_b0, carry0, zero0} !== want[i]) begin
        n_fail++;
        $display("FAIL inc_dec_const[%0d] got %h exp %h", i, {rd_b0, carry0, zero0}, want[i]);
      end
    end
  endtask

  task automatic test_shift();
    int mode [4] = '{1, 5, 6, 6};
    logic [17:0] want [4] = '{{16'h8001, 2'b00}, {16'h0002, 2'b10},
                               {16'h0001, 2'b00}, {16'h0000, 2'b11}};
    for (int i = 0; i < 4; i++) begin
      drive(1, mode[i], 2, 16'h8001, 2, 1);
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== expv(d)) begin
          n_fail++;
          $display("FAIL shift[%0d] dut%0d got %h exp %h", i, d, obs[d], expv(d));
        end
      end
      n_checks++;
      if ({rd_a0, carry0, zero0} !== want[i]) begin
        n_fail++;
        $display("FAIL shift_const[%0d] got %h exp %h", i, {rd_a0, carry0, zero0}, want[i]);
      end
    end
  endtask

  // LOAD r1, CLEAR r0 (zero flag set), reserved mode on r1, INC r7 (range error on the 6-deep bank), NOP.
  task automatic test_illegal();
    int mode [5] = '{1, 2, 7, 3, 0};
    int addr [5] = '{1, 0, 1, 7, 7};
    for (int i = 0; i < 5; i++) begin
      drive(1, mode[i], addr[i], 16'h1234, 1, 7);
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== expv(d)) begin
          n_fail++;
          $display("FAIL illegal[%0d] dut%0d got %h exp %h", i, d, obs[d], expv(d));
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({rd_a0, err0, done0, carry0, zero0} !== {16'h1234, 4'b1001}) begin
          n_fail++;
          $display("FAIL rsvd_mode_const got %h exp 1234/1001", {rd_a0, err0, done0, carry0, zero0});
        end
      end
      if (i == 3) begin
        n_checks++;
        if ({rd_a1, err1, done1, carry1, zero1} !== {16'h1234, 4'b1001}) begin
          n_fail++;
          $display("FAIL bad_addr_const got %h exp 1234/1001", {rd_a1, err1, done1, carry1, zero1});
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({err0, err1, done0, done1} !== 4'b0000) begin
          n_fail++;
          $display("FAIL nop_const got %b exp 0000", {err0, err1, done0, done1});
        end
      end
    end
  endtask

  task automatic test_zero_r0();
    drive(1, 1, 0, 16'h5555, 0, 7);
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== expv(d)) begin
        n_fail++;
        $display("FAIL zero_r0 dut%0d got %h exp %h", d, obs[d], expv(d));
      end
    end
    n_checks++;
    if ({rd_a1, rd_b1, done1, zero1, rd_a0} !== {32'h0, 2'b10, 16'h5555}) begin
      n_fail++;
      $display("FAIL zero_r0_const got %h exp 0/0/10/5555", {rd_a1, rd_b1, done1, zero1, rd_a0});
    end
  endtask

  task automatic test_back_to_back();
    int mode [3] = '{2, 3, 3};
    for (int i = 0; i < 3; i++) begin
      drive(1, mode[i], 4, 0, 4, 4);
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== expv(d)) begin
          n_fail++;
          $display("FAIL back_to_back[%0d] dut%0d got %h exp %h", i, d, obs[d], expv(d));
        end
      end
    end
    n_checks++;
    if (rd_a0 !== 16'h0002) begin
      n_fail++;
      $display("FAIL back_to_back_const got %h exp 0002", rd_a0);
    end
  endtask

  task automatic test_random();
    int data, wa;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: data = 16'hFFFF;
        1: data = 0;
        2: data = 16'h8000 | $urandom_range(0, 3);
        default: data = int'($urandom_range(0, 65535));
      endcase
      wa = int'($urandom_range(0, 7));
      drive($urandom_range(0, 4) != 0, int'($urandom_range(0, 7)), wa, data,
            ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, 7)));
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== expv(d)) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d got %h exp %h", i, d, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 4, 16'hAAAA, 4, 6);
    step();
    drive(1, 1, 6, 16'hFFFF, 4, 6);
    step();
    drive(1, 3, 4, 0, 4, 6);
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== 36'h0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got %h exp 0", d, obs[d]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, i, i + 4);
      step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== 36'h0 || obs[d] !== expv(d)) begin
          n_fail++;
          $display("FAIL post_reset[%0d] dut%0d got %h exp %h", i, d, obs[d], expv(d));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_read();
    test_inc_dec_wrap();
    test_shift();
    test_illegal();
    test_zero_r0();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
